instr_sequencer: RTL and testbench

//  Control-unit phase sequencer for the downsampling processor. Drives the

---
 rtl/instr_sequencer_if.sv | 32 +++
 rtl/instr_sequencer.sv | 118 +++++++++++
 tb/tb_instr_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Handshake bundle between the instruction sequencer and its surroundings:
// decoder/ALU flags and run control in, PC/IR strobes and run status out.
interface instr_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             mem_wait;
  logic             op_end;
  logic             op_jump;
  logic             jump_taken;
  logic             pc_clear;
  logic             ir_load;
  logic             pc_inc;
  logic             pc_load;
  logic [1:0]       phase;
  logic             busy;
  logic             finish;
  logic             timeout;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  start, mem_wait, op_end, op_jump, jump_taken,
    output pc_clear, ir_load, pc_inc, pc_load, phase, busy, finish, timeout,
           instr_count
  );

  modport slave (
    output start, mem_wait, op_end, op_jump, jump_taken,
    input  pc_clear, ir_load, pc_inc, pc_load, phase, busy, finish, timeout,
           instr_count
  );
endinterface

// File: rtl/instr_sequencer.sv
// Four-phase instruction cycle sequencer (FETCH/DECODE/EXEC/WB) with PC
// strobes, memory-stall timeout and a saturating retired-instruction count.
module instr_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 15
) (
  input logic               clk,
  input logic               rst,
  instr_sequencer_if.master bus
);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, WB, DONE} state_t;

  state_t             state;
  logic               is_jump;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               pc_clear, ir_load, pc_inc, pc_load;
  logic [1:0]         phase;
  logic               busy, finish, timeout;
  logic [CNT_W-1:0]   count;

  // Outputs are computed alongside the state they belong to, so every
  // output is a flop and changes only on the edge that enters the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register, counters and sticky flags included, sits on the
      // async reset so a mid-run reset leaves no stale strobe behind.
      state    <= IDLE;
      is_jump  <= 1'b0;
      wait_cnt <= '0;
      pc_clear <= 1'b0;
      ir_load  <= 1'b0;
      pc_inc   <= 1'b0;
      pc_load  <= 1'b0;
      phase    <= 2'd0;
      busy     <= 1'b0;
      finish   <= 1'b0;
      timeout  <= 1'b0;
      count    <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; defaults below are
      // overridden later in the same block to make one-cycle pulses.
      pc_clear <= 1'b0;
      ir_load  <= 1'b0;
      pc_inc   <= 1'b0;
      pc_load  <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state    <= FETCH;
            pc_clear <= 1'b1;
            ir_load  <= 1'b1;
            phase    <= 2'd0;
            busy     <= 1'b1;
            finish   <= 1'b0;
            timeout  <= 1'b0;
            count    <= '0;
          end
        end
        FETCH: begin
          state <= DECODE;
          phase <= 2'd1;
        end
        DECODE: begin
          if (bus.op_end) begin
            state  <= DONE;
            phase  <= 2'd0;
            busy   <= 1'b0;
            finish <= 1'b1;
          end else begin
            state    <= EXEC;
            phase    <= 2'd2;
            is_jump  <= bus.op_jump;
            wait_cnt <= '0;
          end
        end
        EXEC: begin
          if (bus.mem_wait) begin
            if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
              state    <= DONE;
              phase    <= 2'd0;
              busy     <= 1'b0;
              finish   <= 1'b1;
              timeout  <= 1'b1;
              wait_cnt <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end else begin
            state    <= WB;
            phase    <= 2'd3;
            wait_cnt <= '0;
            pc_load  <= is_jump & bus.jump_taken;
            pc_inc   <= ~(is_jump & bus.jump_taken);
            if (count != '1) count <= count + 1'b1;
          end
        end
        WB: begin
          state   <= FETCH;
          phase   <= 2'd0;
          ir_load <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pc_clear    = pc_clear;
  assign bus.ir_load     = ir_load;
  assign bus.pc_inc      = pc_inc;
  assign bus.pc_load     = pc_load;
  assign bus.phase       = phase;
  assign bus.busy        = busy;
  assign bus.finish      = finish;
  assign bus.timeout     = timeout;
  assign bus.instr_count = count;
endmodule

// File: tb/tb_instr_sequencer.sv
// Builds the expected cycle-by-cycle trace of each program from its
// instruction list, then drives two sequencers (16-bit and 2-bit counters).
module tb_instr_sequencer;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, mem_wait = 1'b0, op_end = 1'b0, op_jump = 1'b0, jump_taken = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.CNT_W(16)) bus16 ();
  instr_sequencer_if #(.CNT_W(2))  bus2 ();

  assign bus16.start = start;      assign bus2.start = start;
  assign bus16.mem_wait = mem_wait; assign bus2.mem_wait = mem_wait;
  assign bus16.op_end = op_end;    assign bus2.op_end = op_end;
  assign bus16.op_jump = op_jump;  assign bus2.op_jump = op_jump;
  assign bus16.jump_taken = jump_taken; assign bus2.jump_taken = jump_taken;

  instr_sequencer #(.CNT_W(16), .MAX_WAIT(MAX_WAIT)) dut16 (.clk(clk), .rst(rst), .bus(bus16.master));
  instr_sequencer #(.CNT_W(2),  .MAX_WAIT(MAX_WAIT)) dut2  (.clk(clk), .rst(rst), .bus(bus2.master));

  typedef struct {
    bit is_end;
    bit jump;
    bit taken;
    int waits;
  } instr_t;

  typedef struct {
    bit start, mem_wait, op_end, op_jump, jump_taken;
    bit pc_clear, ir_load, pc_inc, pc_load;
    bit [1:0] phase;
    bit busy, finish, timeout;
    bit [1:0] c2;
    bit [15:0] c16;
  } cyc_t;

  instr_t prog[$];
  cyc_t   tr[$];
  bit     m_fin, m_tmo;
  int     m_c16, m_c2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_vec(cyc_t c);
    return {5'b0, c.pc_clear, c.ir_load, c.pc_inc, c.pc_load, c.phase,
            c.busy, c.finish, c.timeout, c.c2, c.c16};
  endfunction

  function automatic logic [31:0] act_vec();
    return {5'b0, bus16.pc_clear, bus16.ir_load, bus16.pc_inc, bus16.pc_load,
            bus16.phase, bus16.busy, bus16.finish, bus16.timeout,
            bus2.instr_count, bus16.instr_count};
  endfunction

  // A cycle with random don't-care inputs and the current run status.
  function automatic cyc_t noise();
    cyc_t c;
    c = '{default: 0};
    c.mem_wait   = 1'($urandom);
    c.op_end     = 1'($urandom);
    c.op_jump    = 1'($urandom);
    c.jump_taken = 1'($urandom);
    c.finish     = m_fin;
    c.timeout    = m_tmo;
    c.c16        = 16'(m_c16);
    c.c2         = 2'(m_c2);
    return c;
  endfunction

  task automatic build_trace();
    cyc_t c;
    bit   first = 1'b1;
    bit   timed = 1'b0;
    tr.delete();
    c = noise();
    c.start = 1'b1;
    tr.push_back(c);
    m_fin = 0; m_tmo = 0; m_c16 = 0; m_c2 = 0;
    foreach (prog[i]) begin
      c = noise(); c.start = 1'($urandom);
      c.ir_load = 1'b1; c.pc_clear = first; c.busy = 1'b1; c.phase = 2'd0;
      tr.push_back(c);
      first = 1'b0;
      c = noise(); c.start = 1'($urandom);
      c.op_end = prog[i].is_end; c.op_jump = prog[i].jump;
      c.busy = 1'b1; c.phase = 2'd1;
      tr.push_back(c);
      if (prog[i].is_end) break;
      for (int j = 0; j < prog[i].waits && j < MAX_WAIT; j++) begin
        c = noise(); c.start = 1'($urandom);
        c.mem_wait = 1'b1; c.busy = 1'b1; c.phase = 2'd2;
        tr.push_back(c);
      end
      if (prog[i].waits >= MAX_WAIT) begin
        m_tmo = 1'b1;
        timed = 1'b1;
        break;
      end
      c = noise(); c.start = 1'($urandom);
      c.mem_wait = 1'b0; c.jump_taken = prog[i].taken; c.busy = 1'b1; c.phase = 2'd2;
      tr.push_back(c);
      if (m_c16 < 65535) m_c16++;
      if (m_c2 < 3) m_c2++;
      c = noise(); c.start = 1'($urandom);
      c.busy = 1'b1; c.phase = 2'd3;
      c.pc_load = prog[i].jump & prog[i].taken;
      c.pc_inc  = !(prog[i].jump & prog[i].taken);
      tr.push_back(c);
    end
    m_fin = 1'b1;
    if (!timed) m_tmo = 1'b0;
    for (int k = 0; k < 3; k++) tr.push_back(noise());
  endtask

  // Entry k: outputs observed during cycle k, inputs applied for its closing edge.
  task automatic run_trace(input int limit);
    for (int k = 0; k < tr.size() && k < limit; k++) begin
      @(negedge clk);
      check($sformatf("cyc%0d", k), act_vec(), exp_vec(tr[k]));
      start = tr[k].start; mem_wait = tr[k].mem_wait; op_end = tr[k].op_end;
      op_jump = tr[k].op_jump; jump_taken = tr[k].jump_taken;
    end
  endtask

  task automatic add(input bit is_end, input bit jump, input bit taken, input int waits);
    instr_t in;
    in.is_end = is_end; in.jump = jump; in.taken = taken; in.waits = waits;
    prog.push_back(in);
  endtask

  task automatic rand_prog();
    int n, sel, w;
    prog.delete();
    n = $urandom_range(0, 6);
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 7);
      w = (sel < 5) ? 0 : (sel == 5) ? $urandom_range(1, 5) : (sel == 6) ? 14 :
          (($urandom % 4 == 0) ? 15 : 3);
      add(1'b0, 1'($urandom), 1'($urandom), w);
    end
    add(1'b1, 1'($urandom), 1'($urandom), 0);
  endtask

  initial begin
    m_fin = 0; m_tmo = 0; m_c16 = 0; m_c2 = 0;
    @(negedge clk);
    check("reset", act_vec(), 32'h0);
    rst = 1'b0;

    // Three plain instructions then END: pc_inc lands 4, 8, 12 cycles after start.
    prog.delete();
    repeat (3) add(1'b0, 1'b0, 1'b0, 0);
    add(1'b1, 1'b0, 1'b0, 0);
    build_trace(); run_trace(tr.size());
    check("t1_pc_inc_cycles", {29'b0, tr[4].pc_inc, tr[8].pc_inc, tr[12].pc_inc}, 32'h7);

    // Taken / not-taken jump, 5-cycle stall, 14-cycle stall, END with op_jump.
    prog.delete();
    add(1'b0, 1'b1, 1'b1, 0); add(1'b0, 1'b1, 1'b0, 0);
    add(1'b0, 1'b0, 1'b1, 5); add(1'b0, 1'b1, 1'b1, 14);
    add(1'b0, 1'b0, 1'b0, 0); add(1'b1, 1'b1, 1'b1, 0);
    build_trace(); run_trace(tr.size());

    // Stall of MAX_WAIT cycles ends the run with timeout.
    prog.delete();
    add(1'b0, 1'b0, 1'b0, 0); add(1'b0, 1'b1, 1'b1, 15);
    build_trace(); run_trace(tr.size());

    // Restart from a timed-out DONE clears the flags.
    prog.delete();
    add(1'b0, 1'b0, 1'b0, 1); add(1'b1, 1'b0, 1'b0, 0);
    build_trace(); run_trace(tr.size());

    for (int r = 0; r < 30; r++) begin
      rand_prog();
      build_trace(); run_trace(tr.size());
    end

    // Reset while stalled in EXEC: outputs drop at once, no strobe afterwards.
    prog.delete();
    add(1'b0, 1'b1, 1'b1, 8); add(1'b1, 1'b0, 1'b0, 0);
    build_trace(); run_trace(6);
    #2 rst = 1'b1;
    #1 check("rst_async", act_vec(), 32'h0);
    @(negedge clk);
    check("rst_held", act_vec(), 32'h0);
    rst = 1'b0; start = 1'b0; mem_wait = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("post_rst%0d", k), act_vec(), 32'h0);
      mem_wait = 1'($urandom); jump_taken = 1'($urandom);
    end
    m_fin = 0; m_tmo = 0; m_c16 = 0; m_c2 = 0;
    rand_prog();
    build_trace(); run_trace(tr.size());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
